kbbuf_fifo: RTL
===============

Name: kbbuf_fifo

Overview:
- Keyboard buffer FIFO between the SPI command decoder and the CPU.
- Write side receives 16-bit key entries delivered by the SPI "write keyboard buffer (16-bit)" command (kbbuf_data / kbbuf_wren).
- Read side is the CPU register interface: the CPU inspects the head entry and pops it; status (empty, count, overflow) drives a CPU-visible status register and interrupt.
- Show-ahead FIFO: the head entry is always presented on rd_data while non-empty.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 2..8.
- WIDTH, 16, entry width in bits.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- kbbuf_data  input  WIDTH  entry to push; sampled when kbbuf_wren=1.
- kbbuf_wren  input  1  single-cycle push strobe from SPI command decoder.
- rd_pop  input  1  single-cycle pop strobe from CPU bus (read of data register).
- clear  input  1  single-cycle flush strobe from CPU bus.
- ovf_clr  input  1  single-cycle strobe clearing the overflow flag only.
- rd_data  output  WIDTH  head entry; 0 when empty.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- count  output  DEPTH_LOG2+1  number of entries held (0..2^DEPTH_LOG2).
- overflow  output  1  sticky: a push was dropped because the FIFO was full.
- irq  output  1  level interrupt request: !empty || overflow.

Behaviour:
- Storage: 2^DEPTH_LOG2 x WIDTH register array. wr_ptr/rd_ptr are DEPTH_LOG2 bits, wrap modulo depth. count is a separate register; empty=(count==0), full=(count==depth).
- Reset (async): wr_ptr=rd_ptr=0, count=0, overflow=0. Outputs: empty=1, full=0, rd_data=0, irq=0. Array contents are don't-care.
- Push accepted when kbbuf_wren && (!full || pop_eff): store at wr_ptr, wr_ptr+1.
- pop_eff = rd_pop && !empty: rd_ptr+1. rd_pop while empty is ignored; no state change, no error flag.
- count update: +1 on accepted push only, -1 on pop_eff only, unchanged when both.
- Full with simultaneous push and pop: both occur. count stays at depth; the new entry lands in the slot just freed.
- Full with push and no pop: entry dropped, pointers and count unchanged, overflow<=1.
- overflow is sticky. It is cleared by ovf_clr or clear. Setting wins over ovf_clr in the same cycle.
- clear has priority over push and pop in the same cycle: pointers=0, count=0, overflow=0. The coincident push is discarded and does not set overflow.
- Latency: a push at edge N is visible on rd_data/empty/count after edge N (one cycle). A pop at edge N exposes the next entry after edge N.
- rd_data:
  - Combinational from array[rd_ptr] gated to 0 when empty.
  - Must never show stale data after a pop empties the FIFO or after clear.
- Ordering: strict FIFO; entries are read in push order across pointer wrap-around.
- Reset asserted mid-operation: all state returns to reset values immediately; strobes during reset are ignored.

Test Plan:
- Reset, then push 16'h1234, 16'hABCD on consecutive cycles:
  - After first edge: empty=0, rd_data=16'h1234, count=1, irq=1.
  - Pop: rd_data=16'hABCD, count=1. Pop again: empty=1, rd_data=0, irq=0.
- Push 16 entries 16'h0000..16'h000F -> full=1, count=16.
  - 17th push 16'hFFFF: dropped, overflow=1.
  - Pop all 16: values 0..F in order, then empty=1, overflow still 1.
  - Pulse ovf_clr: overflow=0, irq=0.
- Fill to full, then push 16'h5555 with rd_pop in the same cycle -> count stays 16, overflow=0. Draining yields 16'h0001..16'h000F then 16'h5555.
- Wrap: push/pop 40 sequential values interleaved with at most 3 outstanding -> every popped value matches the pushed order; pointers wrap twice without error.
- Fill 5 entries, pulse clear together with kbbuf_wren (16'h7777) and rd_pop -> count=0, empty=1, rd_data=0, overflow=0. Next push of 16'h0042 appears as head.
- rd_pop on empty FIFO -> no change (count=0, overflow=0). Assert reset asynchronously mid-burst with 7 entries held -> empty=1, count=0 before the next clock edge.

Source files
------------

// File: rtl/kbbuf_fifo.sv
// kbbuf_fifo: show-ahead keyboard buffer FIFO between the SPI command decoder (push side) and the CPU (pop/status side)
module kbbuf_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      kbbuf_data,
  input  logic                  kbbuf_wren,
  input  logic                  rd_pop,
  input  logic                  clear,
  input  logic                  ovf_clr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic pop_eff, push_ok, drop;
  assign empty   = count == '0;
  assign full    = count == (DEPTH_LOG2+1)'(DEPTH);
  assign pop_eff = rd_pop && !empty;
  assign push_ok = kbbuf_wren && (!full || pop_eff);
  assign drop    = kbbuf_wren && full && !pop_eff;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign irq     = !empty || overflow;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      count    <= (push_ok && !pop_eff) ? count + 1'b1 :
                  (pop_eff && !push_ok) ? count - 1'b1 : count;
      overflow <= drop || (overflow && !ovf_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !clear && push_ok) mem[wr_ptr] <= kbbuf_data;
  end
endmodule
